// File: rtl/instr_field_buffer.sv
// instr_field_buffer: registered IF/ID stage with a 2-entry FIFO
// and MIPS-style field split of the head instruction.
module instr_field_buffer #(
    parameter logic [31:0] NOP_WORD  = 32'h0000_0000,
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          in_instr,
    input  logic [31:0]          in_pc,
    input  logic                 flush,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [5:0]           opcode,
    output logic [4:0]           rs,
    output logic [4:0]           rt,
    output logic [4:0]           rd,
    output logic [4:0]           shamt,
    output logic [5:0]           funct,
    output logic [15:0]          imm16,
    output logic [25:0]          jump26,
    output logic [31:0]          out_pc,
    output logic [1:0]           occupancy,
    output logic [CNT_WIDTH-1:0] delivered
);

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = 1;

    logic [31:0]          instr_q [2];
    logic [31:0]          pc_q    [2];
    logic                 head_q;
    logic                 tail_q;
    logic [1:0]           occ_q;
    logic [CNT_WIDTH-1:0] del_q;

    logic                 push;
    logic                 pop;
    logic [31:0]          head_instr;
    logic [31:0]          head_pc;

    // Handshake flags come straight from the occupancy register.
    assign in_ready  = (occ_q != 2'd2);
    assign out_valid = (occ_q != 2'd0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    // Select the head entry, or the NOP word when the buffer is empty.
    always_comb begin
        head_instr = NOP_WORD;
        head_pc    = '0;
        if (out_valid) begin
            head_instr = instr_q[head_q];
            head_pc    = pc_q[head_q];
        end
    end

    assign opcode    = head_instr[31:26];
    assign rs        = head_instr[25:21];
    assign rt        = head_instr[20:16];
    assign rd        = head_instr[15:11];
    assign shamt     = head_instr[10:6];
    assign funct     = head_instr[5:0];
    assign imm16     = head_instr[15:0];
    assign jump26    = head_instr[25:0];
    assign out_pc    = head_pc;
    assign occupancy = occ_q;
    assign delivered = del_q;

    // Write accepted words into the tail slot; a flush drops them.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            instr_q[0] <= '0;
            instr_q[1] <= '0;
            pc_q[0]    <= '0;
            pc_q[1]    <= '0;
        end else if (push && !flush) begin
            instr_q[tail_q] <= in_instr;
            pc_q[tail_q]    <= in_pc;
        end
    end

    // Advance pointers and occupancy; flush empties the buffer.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            head_q <= 1'b0;
            tail_q <= 1'b0;
            occ_q  <= 2'd0;
        end else if (flush) begin
            head_q <= 1'b0;
            tail_q <= 1'b0;
            occ_q  <= 2'd0;
        end else begin
            if (push) begin
                tail_q <= ~tail_q;
            end
            if (pop) begin
                head_q <= ~head_q;
            end
            occ_q <= occ_q + {1'b0, push} - {1'b0, pop};
        end
    end

    // Count every consumed head, including one popped during a flush.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            del_q <= '0;
        end else if (pop) begin
            del_q <= del_q + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_instr_field_buffer.sv
// tb_instr_field_buffer: table vectors, directed corner sequences
// and a randomized run against a queue-based reference model.
module tb_instr_field_buffer;

    logic        clock;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [5:0]  opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [5:0]  funct;
    logic [15:0] imm16;
    logic [25:0] jump26;
    logic [31:0] out_pc;
    logic [1:0]  occupancy;
    logic [15:0] delivered;

    int checks = 0;
    int errors = 0;

    logic [63:0] mq [$];
    logic [15:0] mdel;

    instr_field_buffer #(
        .NOP_WORD (32'h0000_0000),
        .CNT_WIDTH(16)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_instr (in_instr),
        .in_pc    (in_pc),
        .flush    (flush),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .opcode   (opcode),
        .rs       (rs),
        .rt       (rt),
        .rd       (rd),
        .shamt    (shamt),
        .funct    (funct),
        .imm16    (imm16),
        .jump26   (jump26),
        .out_pc   (out_pc),
        .occupancy(occupancy),
        .delivered(delivered)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic check_word(input string tag, input logic [31:0] w,
                              input logic [31:0] pc);
        check({tag, "_opcode"}, 64'(opcode), 64'(w[31:26]));
        check({tag, "_rs"},     64'(rs),     64'(w[25:21]));
        check({tag, "_rt"},     64'(rt),     64'(w[20:16]));
        check({tag, "_rd"},     64'(rd),     64'(w[15:11]));
        check({tag, "_shamt"},  64'(shamt),  64'(w[10:6]));
        check({tag, "_funct"},  64'(funct),  64'(w[5:0]));
        check({tag, "_imm16"},  64'(imm16),  64'(w[15:0]));
        check({tag, "_jump26"}, 64'(jump26), 64'(w[25:0]));
        check({tag, "_pc"},     64'(out_pc), 64'(pc));
    endtask

    task automatic compare_model();
        logic [31:0] w;
        logic [31:0] p;
        int n;
        n = mq.size();
        w = 32'h0;
        p = 32'h0;
        if (n > 0) begin
            w = mq[0][63:32];
            p = mq[0][31:0];
        end
        check("m_occ",   64'(occupancy), 64'(n));
        check("m_valid", 64'(out_valid), 64'(n > 0));
        check("m_ready", 64'(in_ready),  64'(n < 2));
        check("m_del",   64'(delivered), 64'(mdel));
        check_word("m", w, p);
    endtask

    task automatic model_reset();
        mq.delete();
        mdel = 16'h0;
    endtask

    // Drive one cycle from a negedge, update the model, check at the next negedge.
    task automatic cycle(input logic v, input logic [31:0] ins,
                         input logic [31:0] pc, input logic fl,
                         input logic ordy);
        bit do_push;
        bit do_pop;
        in_valid  = v;
        in_instr  = ins;
        in_pc     = pc;
        flush     = fl;
        out_ready = ordy;
        do_push = v && (mq.size() < 2);
        do_pop  = ordy && (mq.size() > 0);
        if (do_pop) mdel = mdel + 16'h1;
        if (fl) begin
            mq.delete();
        end else begin
            if (do_pop)  void'(mq.pop_front());
            if (do_push) mq.push_back({ins, pc});
        end
        @(posedge clock);
        @(negedge clock);
        compare_model();
    endtask

    task automatic hard_reset();
        @(negedge clock);
        reset = 1'b1;
        in_valid = 1'b0;
        flush = 1'b0;
        out_ready = 1'b0;
        model_reset();
        @(negedge clock);
        reset = 1'b0;
        #1;
        compare_model();
    endtask

    typedef struct {
        logic        v;
        logic [31:0] ins;
        logic [31:0] pc;
        logic        fl;
        logic        rdy;
        logic [1:0]  occ;
        logic [31:0] word;
        logic [31:0] epc;
        logic [15:0] del;
    } vec_t;

    vec_t tbl [6];

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_instr  = 32'h0;
        in_pc     = 32'h0;
        flush     = 1'b0;
        out_ready = 1'b0;
        model_reset();

        tbl[0] = '{1'b1, 32'h8CA2_0010, 32'h40, 1'b0, 1'b1, 2'd1, 32'h8CA2_0010, 32'h40, 16'd0};
        tbl[1] = '{1'b0, 32'h1111_1111, 32'h99, 1'b0, 1'b1, 2'd0, 32'h0000_0000, 32'h00, 16'd1};
        tbl[2] = '{1'b1, 32'h0C00_0123, 32'h44, 1'b0, 1'b0, 2'd1, 32'h0C00_0123, 32'h44, 16'd1};
        tbl[3] = '{1'b1, 32'h0022_1820, 32'h48, 1'b0, 1'b0, 2'd2, 32'h0C00_0123, 32'h44, 16'd1};
        tbl[4] = '{1'b1, 32'hDEAD_BEEF, 32'h4C, 1'b0, 1'b1, 2'd1, 32'h0022_1820, 32'h48, 16'd2};
        tbl[5] = '{1'b0, 32'h0000_0000, 32'h00, 1'b0, 1'b1, 2'd0, 32'h0000_0000, 32'h00, 16'd3};

        @(negedge clock);
        @(negedge clock);
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_ready", 64'(in_ready),  64'd1);
        check("rst_del",   64'(delivered), 64'd0);
        reset = 1'b0;
        #1;
        compare_model();

        for (int i = 0; i < 6; i++) begin
            cycle(tbl[i].v, tbl[i].ins, tbl[i].pc, tbl[i].fl, tbl[i].rdy);
            check("tbl_occ",   64'(occupancy), 64'(tbl[i].occ));
            check("tbl_ready", 64'(in_ready),  64'(tbl[i].occ != 2'd2));
            check("tbl_del",   64'(delivered), 64'(tbl[i].del));
            check_word("tbl", tbl[i].word, tbl[i].epc);
            if (i == 0) begin
                check("lw_opcode", 64'(opcode), 64'h23);
                check("lw_rs",     64'(rs),     64'd5);
                check("lw_rt",     64'(rt),     64'd2);
                check("lw_imm",    64'(imm16),  64'h10);
            end
            if (i == 3) begin
                check("jal_op", 64'(opcode), 64'd3);
                check("jal_j",  64'(jump26), 64'h123);
            end
            if (i == 4) begin
                check("add_rd", 64'(rd),    64'd3);
                check("add_fn", 64'(funct), 64'h20);
            end
        end

        // occupancy 1, ten back-to-back push+pop cycles
        cycle(1'b1, 32'hA000_0000, 32'h100, 1'b0, 1'b0);
        for (int i = 1; i <= 10; i++) begin
            cycle(1'b1, 32'hA000_0000 + 32'(i), 32'h100 + 32'(4 * i),
                  1'b0, 1'b1);
            check("pp_occ",  64'(occupancy), 64'd1);
            check("pp_word", 64'(jump26),    64'(i));
        end
        check("pp_del", 64'(delivered), 64'd13);

        // flush at occupancy 2 with in_valid and out_ready high
        cycle(1'b1, 32'hB000_0001, 32'h200, 1'b0, 1'b0);
        check("fl_full", 64'(occupancy), 64'd2);
        cycle(1'b1, 32'hCCCC_CCCC, 32'h300, 1'b1, 1'b1);
        check("fl_occ",   64'(occupancy), 64'd0);
        check("fl_valid", 64'(out_valid), 64'd0);
        check("fl_op",    64'(opcode),    64'd0);
        check("fl_del",   64'(delivered), 64'd14);
        // flush at occupancy 1 discards a handshaken word
        cycle(1'b1, 32'hB000_0002, 32'h204, 1'b0, 1'b0);
        cycle(1'b1, 32'hDDDD_DDDD, 32'h208, 1'b1, 1'b0);
        cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        check("fl1_valid", 64'(out_valid), 64'd0);

        // asynchronous reset at occupancy 2, delivered 7
        hard_reset();
        cycle(1'b1, 32'hE000_0000, 32'h400, 1'b0, 1'b0);
        for (int i = 1; i <= 7; i++)
            cycle(1'b1, 32'hE000_0000 + 32'(i), 32'h400, 1'b0, 1'b1);
        cycle(1'b1, 32'hE000_0010, 32'h404, 1'b0, 1'b0);
        check("ar_occ", 64'(occupancy), 64'd2);
        check("ar_del", 64'(delivered), 64'd7);
        #2;
        reset = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        #1;
        check("ar_now_valid", 64'(out_valid), 64'd0);
        check("ar_now_ready", 64'(in_ready),  64'd1);
        check("ar_now_occ",   64'(occupancy), 64'd0);
        check("ar_now_del",   64'(delivered), 64'd0);
        check_word("ar_now", 32'h0, 32'h0);
        model_reset();
        @(negedge clock);
        reset = 1'b0;
        #1;
        compare_model();
        @(negedge clock);

        // delivered wrap after 65535 pops
        cycle(1'b1, 32'h0, 32'h0, 1'b0, 1'b0);
        for (int i = 1; i <= 65535; i++)
            cycle(1'b1, 32'(i), 32'(i), 1'b0, 1'b1);
        check("wrap_max", 64'(delivered), 64'hFFFF);
        cycle(1'b1, 32'h1234_5678, 32'h0, 1'b0, 1'b1);
        check("wrap_zero", 64'(delivered), 64'h0);

        // randomized traffic against the queue model
        hard_reset();
        for (int i = 0; i < 600; i++) begin
            cycle(($urandom % 4) != 0, $urandom, $urandom,
                  ($urandom % 16) == 0, ($urandom % 3) != 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
